// File: rtl/bus_slave_pkg.sv
// Shared definitions for the serial-bus slave port.
//   state_e        : slave FSM state encoding
//   BURST_FLAG_IDX : header burst descriptor bit holding the burst flag
//   hdr_len()      : serial header length for given address/burst widths
//   DEF_*          : default widths shared with the master port
package bus_slave_pkg;

  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_BURST_W    = 12;
  localparam int BURST_FLAG_IDX = 0;

  typedef enum logic [2:0] {
    IDLE, HDR, WDATA, WCOMMIT, RFETCH, RWAIT, RSEND, SPLITGAP
  } state_e;

  // Address and burst descriptor (flag + length) travel in parallel, so the
  // header lasts as long as the wider of the two.
  function automatic int hdr_len(input int aw, input int bw);
    return (aw > bw + 1) ? aw : bw + 1;
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// LSB-first shift register with parallel load and a beat bit counter.
// Ports:
//   clk, reset      : clock, async active-low reset
//   load, load_data : parallel load (also restarts the bit counter)
//   shift_en        : shift one bit in at the MSB, out of the LSB
//   shift_in        : serial input bit
//   q               : register contents (q[0] is the current serial out bit)
//   last            : the next shift completes a DATA_W-bit beat
module bus_shift_reg
  import bus_slave_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  input  logic              shift_in,
  output logic [DATA_W-1:0] q,
  output logic              last
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] q_q, q_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  assign q    = q_q;
  assign last = (cnt_q == CW'(DATA_W - 1));

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (load) begin
      q_d   = load_data;
      cnt_d = '0;
    end else if (shift_en) begin
      // {shift_in, q} >> 1 keeps the low DATA_W bits = {shift_in, q[W-1:1]}
      q_d   = DATA_W'({shift_in, q_q} >> 1);
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_slave_port.sv
// Serial-bus slave port: deserialises a request header (address + burst
// descriptor), then moves write data into, or read data out of, the local
// memory one DATA_W-bit beat at a time through a single-cycle strobe port.
// Optional macro SPLIT_EN: read bursts pause for SPLIT_GAP idle cycles after
// every SPLIT_BEATS non-final beats (split = 1 during the pause).
// Ports:
//   clk, reset                  : clock, async active-low reset
//   read_en, write_en           : request type, latched on header bit 0
//   master_valid / slave_ready  : rx bit handshake (rx_addr, rx_burst, rx_data)
//   slave_valid / master_ready  : tx bit handshake (tx_data)
//   mem_addr, mem_wdata, mem_rd, mem_wr, mem_rdata : local memory port
//   split                       : split gap in progress
module bus_slave_port
  import bus_slave_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BURST_W     = DEF_BURST_W,
  parameter int SPLIT_BEATS = 8,
  parameter int SPLIT_GAP   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_en,
  input  logic              write_en,
  input  logic              master_valid,
  input  logic              master_ready,
  output logic              slave_valid,
  output logic              slave_ready,
  input  logic              rx_addr,
  input  logic              rx_burst,
  input  logic              rx_data,
  output logic              tx_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              split
);

  localparam int HDR_LEN = hdr_len(ADDR_W, BURST_W);
  localparam int HW      = $clog2(HDR_LEN);
  localparam int SBW     = $clog2(SPLIT_BEATS + 1);
  localparam int GW      = $clog2(SPLIT_GAP + 1);

  state_e             state_q, state_d;
  logic [HW-1:0]      hdr_cnt_q, hdr_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W:0]   burst_q, burst_d;
  logic [BURST_W-1:0] left_q, left_d;     // beats remaining after the current one
  logic               rd_q, rd_d, wr_q, wr_d;
  logic [SBW-1:0]     sb_cnt_q, sb_cnt_d; // read beats since the last split gap
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

  logic              acc, split_go;
  logic [DATA_W-1:0] rx_q, tx_q;
  logic              rx_last, tx_last, tx_unused;

  assign acc         = master_valid & slave_ready;
  assign slave_ready = state_q inside {IDLE, HDR, WDATA};
  assign slave_valid = (state_q == RSEND);
  assign tx_data     = slave_valid & tx_q[0];
  assign mem_rd      = (state_q == RFETCH);
  assign mem_wr      = (state_q == WCOMMIT);
  assign mem_addr    = addr_q;
  assign mem_wdata   = rx_q;
  // upper tx bits only feed the shift chain inside the register
  assign tx_unused   = ^(tx_q >> 1);

`ifdef SPLIT_EN
  assign split_go = (sb_cnt_q == SBW'(SPLIT_BEATS - 1));
  assign split    = (state_q == SPLITGAP);
`else
  assign split_go = 1'b0;
  assign split    = 1'b0;
`endif

  bus_shift_reg #(.DATA_W(DATA_W)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ({DATA_W{1'b0}}),
    .shift_en  (acc && state_q == WDATA),
    .shift_in  (rx_data),
    .q         (rx_q),
    .last      (rx_last)
  );

  bus_shift_reg #(.DATA_W(DATA_W)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (state_q == RWAIT),
    .load_data (mem_rdata),
    .shift_en  (state_q == RSEND && master_ready),
    .shift_in  (1'b0),
    .q         (tx_q),
    .last      (tx_last)
  );

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    left_d    = left_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    sb_cnt_d  = sb_cnt_q;
    gap_cnt_d = gap_cnt_q;

    // Header bit i lands in addr[i] / burst[i]; bits past a field are dropped.
    if (acc && (state_q == IDLE || state_q == HDR)) begin
      for (int i = 0; i < ADDR_W; i++)
        if (hdr_cnt_q == HW'(i)) addr_d[i] = rx_addr;
      for (int i = 0; i <= BURST_W; i++)
        if (hdr_cnt_q == HW'(i)) burst_d[i] = rx_burst;
      hdr_cnt_d = hdr_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: if (acc) begin
        rd_d     = read_en;
        wr_d     = write_en;
        sb_cnt_d = '0;
        state_d  = HDR;
      end
      HDR: if (acc && hdr_cnt_q == HW'(HDR_LEN - 1)) begin
        hdr_cnt_d = '0;
        // burst_d: the last header bit may still be landing this cycle
        left_d = burst_d[BURST_FLAG_IDX] ? burst_d[BURST_W:1] : '0;
        unique case ({rd_q, wr_q})
          2'b10:   state_d = RFETCH;
          2'b01:   state_d = WDATA;
          default: state_d = IDLE;
        endcase
      end
      WDATA: if (acc && rx_last) state_d = WCOMMIT;
      WCOMMIT: begin
        if (left_q == '0) state_d = IDLE;
        else begin
          left_d  = left_q - 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = WDATA;
        end
      end
      RFETCH: state_d = RWAIT;
      RWAIT:  state_d = RSEND;
      RSEND: if (master_ready && tx_last) begin
        if (left_q == '0) state_d = IDLE;
        else begin
          left_d = left_q - 1'b1;
          addr_d = addr_q + 1'b1;
          if (split_go) begin
            sb_cnt_d  = '0;
            gap_cnt_d = '0;
            state_d   = SPLITGAP;
          end else begin
            sb_cnt_d = sb_cnt_q + 1'b1;
            state_d  = RFETCH;
          end
        end
      end
      SPLITGAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GW'(SPLIT_GAP - 1)) begin
          gap_cnt_d = '0;
          state_d   = RFETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hdr_cnt_q <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      left_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      sb_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      left_q    <= left_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      sb_cnt_q  <= sb_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule
